alu_issue_ctrl: RTL and testbench

- Command-driven sequencer sitting directly upstream of the ALU.
- Holds the accumulator (ACC) and B operand registers, drives the ALU operand/operation/enable inputs, and writes the combinational ALU result back into ACC.
- Accepts one command at a time over a valid/ready handshake and signals completion with a one-cycle done pulse.

---
 rtl/alu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the ALU: owns ACC/B, issues one ALU op per command.
// Optional OP_COUNT_EN adds a 16-bit count of completed ALU operations.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [OPW-1:0]   alu_operation,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] b_reg,
  output logic             zero_flag,
  output logic             done
`ifdef OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_ALU   = 2'b00,
    K_LDACC = 2'b01,
    K_LDB   = 2'b10,
    K_NOP   = 2'b11
  } kind_t;

  state_t state;

  // Gated with rst_n so no command appears acceptable while reset is held.
  assign cmd_ready = rst_n && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      b_reg         <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      alu_operation <= '0;
      alu_enable    <= 1'b0;
      zero_flag     <= 1'b0;
      done          <= 1'b0;
`ifdef OP_COUNT_EN
      op_count      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            case (cmd_kind)
              K_ALU: begin
                alu_operand1  <= acc;
                alu_operand2  <= b_reg;
                alu_operation <= cmd_op;
                alu_enable    <= 1'b1;
                state         <= S_ISSUE;
              end
              K_LDACC: begin
                acc   <= cmd_imm;
                done  <= 1'b1;
                state <= S_DONE;
              end
              K_LDB: begin
                b_reg <= cmd_imm;
                done  <= 1'b1;
                state <= S_DONE;
              end
              default: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
        end
        S_ISSUE: begin
          acc        <= alu_result;
          zero_flag  <= (alu_result == '0);
          alu_enable <= 1'b0;
          done       <= 1'b1;
          state      <= S_DONE;
`ifdef OP_COUNT_EN
          op_count   <= op_count + 16'd1;
`endif
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          alu_enable <= 1'b0;
          done       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: acts as the ALU and tracks ACC/B/zero in a model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic [7:0] alu_operand1, alu_operand2;
  logic [2:0] alu_operation;
  logic       alu_enable;
  logic [7:0] alu_result;
  logic [7:0] acc, b_reg;
  logic       zero_flag, done;
`ifdef OP_COUNT_EN
  logic [15:0] op_count;
`endif

  int passed = 0;
  int total  = 0;

  // reference state
  logic [7:0] m_acc, m_b;
  logic       m_zero;
  int         m_cnt;

  // ALU stand-in driven by the bench; force_en lets a test dictate the result
  logic       force_en;
  logic [7:0] force_val;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return b;
      3'd6: return {a[6:0], 1'b0};
      default: return ~a;
    endcase
  endfunction

  assign alu_result = !alu_enable ? 8'hA5 :
                      force_en ? force_val : alu_fn(alu_operand1, alu_operand2, alu_operation);

  alu_issue_ctrl #(.WIDTH(8), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_enable(alu_enable),
    .alu_result(alu_result),
    .acc(acc), .b_reg(b_reg), .zero_flag(zero_flag), .done(done)
`ifdef OP_COUNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] expected_result(input logic [2:0] op, input bit fz,
                                                  input logic [7:0] fv);
    return fz ? fv : alu_fn(m_acc, m_b, op);
  endfunction

  // Drives one command from IDLE and checks it through DONE and back to IDLE.
  task automatic drive_cmd(input logic [1:0] kind, input logic [2:0] op,
                           input logic [7:0] imm, input bit fz, input logic [7:0] fv);
    logic [7:0] r;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL ready_idle: got %b exp 1", cmd_ready); else passed++;
    cmd_valid = 1'b1; cmd_kind = kind; cmd_op = op; cmd_imm = imm;
    force_en = fz; force_val = fv;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_kind = 2'($urandom); cmd_op = 3'($urandom); cmd_imm = 8'($urandom);
    if (kind == 2'b00) begin
      total++; if (alu_enable !== 1'b1) $display("FAIL issue_en: got %b exp 1", alu_enable); else passed++;
      total++; if (alu_operand1 !== m_acc) $display("FAIL issue_op1: got %h exp %h", alu_operand1, m_acc); else passed++;
      total++; if (alu_operand2 !== m_b) $display("FAIL issue_op2: got %h exp %h", alu_operand2, m_b); else passed++;
      total++; if (alu_operation !== op) $display("FAIL issue_opc: got %h exp %h", alu_operation, op); else passed++;
      total++; if ({cmd_ready, done} !== 2'b00) $display("FAIL issue_rdy_done: got %b exp 00", {cmd_ready, done}); else passed++;
      r = expected_result(op, fz, fv);
      m_acc = r; m_zero = (r == 8'h00); m_cnt++;
      @(negedge clk);
    end else if (kind == 2'b01) m_acc = imm;
    else if (kind == 2'b10) m_b = imm;
    total++; if ({done, alu_enable, cmd_ready} !== 3'b100) $display("FAIL done_phase: got %b exp 100", {done, alu_enable, cmd_ready}); else passed++;
    total++; if (acc !== m_acc) $display("FAIL acc: got %h exp %h", acc, m_acc); else passed++;
    total++; if (b_reg !== m_b) $display("FAIL b_reg: got %h exp %h", b_reg, m_b); else passed++;
    total++; if (zero_flag !== m_zero) $display("FAIL zero_flag: got %b exp %b", zero_flag, m_zero); else passed++;
    @(negedge clk);
    total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL back_idle: got %b exp 01", {done, cmd_ready}); else passed++;
`ifdef OP_COUNT_EN
    total++; if (op_count !== 16'(m_cnt)) $display("FAIL op_count: got %0d exp %0d", op_count, m_cnt); else passed++;
`endif
    force_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 3'd3; cmd_imm = 8'h77;
    force_en = 1'b0; force_val = 8'h00;
    m_acc = 8'h00; m_b = 8'h00; m_zero = 1'b0; m_cnt = 0;
    repeat (3) @(negedge clk);
    total++; if ({acc, b_reg, alu_operand1, alu_operand2} !== 32'h0) $display("FAIL rst_regs: got %h exp 0", {acc, b_reg, alu_operand1, alu_operand2}); else passed++;
    total++; if ({alu_operation, alu_enable, zero_flag, done, cmd_ready} !== 7'b0) $display("FAIL rst_ctrl: got %b exp 0", {alu_operation, alu_enable, zero_flag, done, cmd_ready}); else passed++;
`ifdef OP_COUNT_EN
    total++; if (op_count !== 16'h0) $display("FAIL rst_count: got %h exp 0", op_count); else passed++;
`endif
    cmd_valid = 1'b0; rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", cmd_ready); else passed++;
  endtask

  task automatic test_loads;
    drive_cmd(2'b01, 3'd0, 8'h0D, 1'b0, 8'h00);
    drive_cmd(2'b10, 3'd0, 8'h03, 1'b0, 8'h00);
    total++; if ({acc, b_reg} !== 16'h0D03) $display("FAIL load_pair: got %h exp 0d03", {acc, b_reg}); else passed++;
  endtask

  task automatic test_alu_op;
    drive_cmd(2'b00, 3'd0, 8'hEE, 1'b1, 8'h10);
    total++; if ({acc, zero_flag} !== {8'h10, 1'b0}) $display("FAIL alu_add: got %h exp 020", {acc, zero_flag}); else passed++;
  endtask

  task automatic test_zero_flag;
    drive_cmd(2'b00, 3'd1, 8'h00, 1'b1, 8'h00);
    total++; if (zero_flag !== 1'b1) $display("FAIL zero_set: got %b exp 1", zero_flag); else passed++;
    drive_cmd(2'b01, 3'd0, 8'h55, 1'b0, 8'h00);
    total++; if ({acc, zero_flag} !== {8'h55, 1'b1}) $display("FAIL zero_hold: got %h exp ab", {acc, zero_flag}); else passed++;
    drive_cmd(2'b11, 3'd0, 8'hFF, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 3'd0;
    @(negedge clk);
    total++; if ({alu_enable, cmd_ready} !== 2'b10) $display("FAIL b2b_issue1: got %b exp 10", {alu_enable, cmd_ready}); else passed++;
    r = alu_fn(m_acc, m_b, 3'd0); m_acc = r; m_zero = (r == 8'h00); m_cnt++;
    cmd_op = 3'd4;
    @(negedge clk);
    total++; if ({done, cmd_ready, alu_enable} !== 3'b100) $display("FAIL b2b_done1: got %b exp 100", {done, cmd_ready, alu_enable}); else passed++;
    @(negedge clk);
    total++; if ({cmd_ready, done, alu_enable} !== 3'b100) $display("FAIL b2b_idle: got %b exp 100", {cmd_ready, done, alu_enable}); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if ({alu_enable, alu_operand1, alu_operation} !== {1'b1, m_acc, 3'd4}) $display("FAIL b2b_issue2: got %h exp %h", {alu_enable, alu_operand1, alu_operation}, {1'b1, m_acc, 3'd4}); else passed++;
    r = alu_fn(m_acc, m_b, 3'd4); m_acc = r; m_zero = (r == 8'h00); m_cnt++;
    @(negedge clk);
    total++; if ({done, acc, zero_flag} !== {1'b1, m_acc, m_zero}) $display("FAIL b2b_done2: got %h exp %h", {done, acc, zero_flag}, {1'b1, m_acc, m_zero}); else passed++;
    @(negedge clk);
    total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL b2b_end: got %b exp 01", {done, cmd_ready}); else passed++;
  endtask

  task automatic test_reset_mid_issue;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (alu_enable !== 1'b1) $display("FAIL rmi_issue: got %b exp 1", alu_enable); else passed++;
    rst_n = 1'b0;
    m_acc = 8'h00; m_b = 8'h00; m_zero = 1'b0; m_cnt = 0;
    #1;
    total++; if ({acc, b_reg, alu_enable, done, zero_flag} !== 19'h0) $display("FAIL rmi_abort: got %h exp 0", {acc, b_reg, alu_enable, done, zero_flag}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rmi_ready: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    total++; if ({done, acc} !== 9'h0) $display("FAIL rmi_nodone: got %h exp 0", {done, acc}); else passed++;
`ifdef OP_COUNT_EN
    total++; if (op_count !== 16'h0) $display("FAIL rmi_count: got %0d exp 0", op_count); else passed++;
`endif
    drive_cmd(2'b10, 3'd0, 8'h21, 1'b0, 8'h00);
    drive_cmd(2'b00, 3'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      bit fz;
      fz = ($urandom_range(0, 7) == 0);
      drive_cmd(2'($urandom), 3'($urandom), 8'($urandom), fz, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_alu_op();
    test_zero_flag();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
